heater_sequencer: RTL and testbench

Supervisory controller for the hotend/bed bang-bang temperature regulator. It owns the regulator's threshold input and gates its heater output.
- Ramps the threshold toward a commanded target.
- Waits for temperature to settle inside a band, then reports ready to the motion sequencer.
- Latches a fault on over-temperature or thermal runaway (heater on, temperature not rising).

---
 rtl/heater_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_heater_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/heater_sequencer.sv
// Supervisory sequencer for the bang-bang heater regulator: ramps the regulator
// threshold, qualifies settling, and latches over-temperature / runaway faults.
module heater_sequencer #(
  parameter int         TICK_CYCLES    = 50000000,
  parameter logic [7:0] RAMP_STEP      = 8'd2,
  parameter logic [7:0] BAND           = 8'd3,
  parameter int         SETTLE_TICKS   = 5,
  parameter int         RUNAWAY_TICKS  = 30,
  parameter logic [7:0] MIN_RISE       = 8'd2,
  parameter logic [7:0] MAX_TEMP       = 8'd250,
  parameter logic [7:0] DEFAULT_TARGET = 8'd180
) (
  input  logic       i_Clock50MHz,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic [7:0] i_Target,
  input  logic       i_Target_Load,
  input  logic [7:0] i_Live,
  input  logic       i_Regulator,
  input  logic       i_Fault_Clear,
  output logic [7:0] o_Thresh,
  output logic       o_Heater,
  output logic       o_Ready,
  output logic       o_Fault,
  output logic [2:0] o_State
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RAMP   = 3'd1,
    SETTLE = 3'd2,
    HOLD   = 3'd3,
    FAULT  = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    r_target;
  logic [7:0]    settle_cnt;
  logic [15:0]   wd_cnt;
  logic [7:0]    wd_ref;
  logic          wd_armed;

  logic       tick;
  logic       active;
  logic       overtemp;
  logic       in_band;
  logic       wd_arm_cond;
  logic       runaway_trip;
  logic [8:0] live_diff;
  logic [8:0] thresh_up;
  logic [8:0] thresh_dn;
  logic [8:0] target_up;
  logic [7:0] target_clamped;

  assign tick     = (tick_cnt == TW'(TICK_CYCLES - 1));
  assign active   = (state == RAMP) || (state == SETTLE) || (state == HOLD);
  assign overtemp = (i_Live > MAX_TEMP);

  assign live_diff = (i_Live >= r_target) ? ({1'b0, i_Live} - {1'b0, r_target})
                                          : ({1'b0, r_target} - {1'b0, i_Live});
  assign in_band   = (live_diff <= {1'b0, BAND});

  // HOLD is deliberately exempt: the regulator cycling around setpoint is normal there.
  assign wd_arm_cond  = ((state == RAMP) || (state == SETTLE)) && o_Heater && (i_Live < o_Thresh);
  assign runaway_trip = wd_arm_cond && wd_armed && tick &&
                        (wd_cnt == 16'(RUNAWAY_TICKS - 1)) &&
                        ({1'b0, i_Live} < ({1'b0, wd_ref} + {1'b0, MIN_RISE}));

  assign thresh_up      = {1'b0, o_Thresh} + {1'b0, RAMP_STEP};
  assign thresh_dn      = {1'b0, o_Thresh} - {1'b0, RAMP_STEP};
  assign target_up      = {1'b0, r_target} + {1'b0, RAMP_STEP};
  assign target_clamped = (i_Target > MAX_TEMP) ? MAX_TEMP : i_Target;

  assign o_State = state;

  always_ff @(posedge i_Clock50MHz) begin
    if (i_Reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      r_target   <= DEFAULT_TARGET;
      settle_cnt <= '0;
      wd_cnt     <= '0;
      wd_ref     <= '0;
      wd_armed   <= 1'b0;
      o_Thresh   <= '0;
      o_Heater   <= 1'b0;
      o_Ready    <= 1'b0;
      o_Fault    <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      if (!wd_arm_cond) begin
        wd_armed <= 1'b0;
        wd_cnt   <= '0;
      end else if (!wd_armed) begin
        wd_armed <= 1'b1;
        wd_ref   <= i_Live;
        wd_cnt   <= '0;
      end else if (tick) begin
        if (wd_cnt == 16'(RUNAWAY_TICKS - 1)) begin
          wd_cnt <= '0;
          wd_ref <= i_Live;
        end else begin
          wd_cnt <= wd_cnt + 16'd1;
        end
      end

      if (overtemp || runaway_trip) begin
        state      <= FAULT;
        o_Fault    <= 1'b1;
        o_Heater   <= 1'b0;
        o_Thresh   <= '0;
        o_Ready    <= 1'b0;
        settle_cnt <= '0;
      end else if (!i_Enable && active) begin
        state      <= IDLE;
        o_Heater   <= 1'b0;
        o_Thresh   <= '0;
        o_Ready    <= 1'b0;
        settle_cnt <= '0;
      end else if (i_Target_Load && (state != FAULT)) begin
        r_target <= target_clamped;
        if (active) begin
          state      <= RAMP;
          o_Heater   <= i_Regulator;
          o_Ready    <= 1'b0;
          settle_cnt <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
            o_Heater <= 1'b0;
            o_Thresh <= '0;
            if (i_Enable && (r_target != 8'd0)) begin
              state    <= RAMP;
              o_Thresh <= i_Live;
              o_Heater <= i_Regulator;
            end
          end
          RAMP: begin
            o_Heater <= i_Regulator;
            if (o_Thresh == r_target) begin
              state      <= SETTLE;
              settle_cnt <= '0;
            end else if (tick) begin
              if (o_Thresh < r_target)
                o_Thresh <= (thresh_up >= {1'b0, r_target}) ? r_target : thresh_up[7:0];
              else
                o_Thresh <= ({1'b0, o_Thresh} <= target_up) ? r_target : thresh_dn[7:0];
            end
          end
          SETTLE: begin
            o_Heater <= i_Regulator;
            if (tick) begin
              if (!in_band) begin
                settle_cnt <= '0;
              end else if (settle_cnt == 8'(SETTLE_TICKS - 1)) begin
                state      <= HOLD;
                o_Ready    <= 1'b1;
                settle_cnt <= '0;
              end else begin
                settle_cnt <= settle_cnt + 8'd1;
              end
            end
          end
          HOLD: begin
            o_Heater <= i_Regulator;
            o_Ready  <= 1'b1;
            if (tick && !in_band) begin
              state      <= SETTLE;
              o_Ready    <= 1'b0;
              settle_cnt <= '0;
            end
          end
          FAULT: begin
            o_Fault  <= 1'b1;
            o_Heater <= 1'b0;
            o_Thresh <= '0;
            o_Ready  <= 1'b0;
            if (i_Fault_Clear) begin
              state   <= IDLE;
              o_Fault <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            o_Heater <= 1'b0;
            o_Thresh <= '0;
            o_Ready  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_heater_sequencer.sv
// Directed bench for heater_sequencer with a 4-cycle tick and 3-tick runaway window.
module tb_heater_sequencer;

  logic       i_Clock50MHz = 1'b0;
  logic       i_Reset;
  logic       i_Enable;
  logic [7:0] i_Target;
  logic       i_Target_Load;
  logic [7:0] i_Live;
  logic       i_Regulator;
  logic       i_Fault_Clear;
  logic [7:0] o_Thresh;
  logic       o_Heater;
  logic       o_Ready;
  logic       o_Fault;
  logic [2:0] o_State;

  heater_sequencer #(
    .TICK_CYCLES   (4),
    .RUNAWAY_TICKS (3)
  ) dut (
    .i_Clock50MHz  (i_Clock50MHz),
    .i_Reset       (i_Reset),
    .i_Enable      (i_Enable),
    .i_Target      (i_Target),
    .i_Target_Load (i_Target_Load),
    .i_Live        (i_Live),
    .i_Regulator   (i_Regulator),
    .i_Fault_Clear (i_Fault_Clear),
    .o_Thresh      (o_Thresh),
    .o_Heater      (o_Heater),
    .o_Ready       (o_Ready),
    .o_Fault       (o_Fault),
    .o_State       (o_State)
  );

  always #5 i_Clock50MHz = ~i_Clock50MHz;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_Clock50MHz);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (o_State == s) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic [2:0] st, input logic [7:0] th,
                               input logic ht, input logic rd, input logic ft);
    check({tag, "_state"},  o_State,  st);
    check({tag, "_thresh"}, o_Thresh, th);
    check({tag, "_heater"}, o_Heater, ht);
    check({tag, "_ready"},  o_Ready,  rd);
    check({tag, "_fault"},  o_Fault,  ft);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    int n;
    int steps;
    int last_t;
    int d;
    logic [7:0] prev;

    i_Reset = 1'b1; i_Enable = 1'b0; i_Target = 8'd0; i_Target_Load = 1'b0;
    i_Live = 8'd100; i_Regulator = 1'b0; i_Fault_Clear = 1'b0;
    repeat (3) step();
    check_outputs("reset", 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Ramp from 100 toward the default target of 180, one 2-degree step per tick.
    i_Reset = 1'b0; i_Enable = 1'b1;
    step();
    check("ramp_entry_state", o_State, 3'd1);
    check("ramp_entry_thresh", o_Thresh, 8'd100);
    prev = 8'd100; steps = 0; last_t = 0;
    for (int t = 1; t <= 400 && o_State == 3'd1; t++) begin
      step();
      if (o_State == 3'd1 && o_Thresh != prev) begin
        d = int'(o_Thresh) - int'(prev);
        check("ramp_delta", d, 2);
        if (steps > 0) check("ramp_spacing", t - last_t, 4);
        steps++;
        last_t = t;
        prev = o_Thresh;
        i_Live = i_Live + 8'd2;
      end
    end
    check("ramp_done_state", o_State, 3'd2);
    check("ramp_done_thresh", o_Thresh, 8'd180);
    check("ramp_steps", steps, 40);

    // Settle with live wandering 178..182; five in-band ticks reach HOLD.
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      i_Live = 8'(178 + (i % 5));
      step();
      if (o_State == 3'd3) begin
        n = i;
        break;
      end
    end
    check("settle_time_ok", (n >= 17 && n <= 20), 1);
    check("hold_state", o_State, 3'd3);
    check("hold_ready", o_Ready, 1'b1);

    i_Live = 8'd180; i_Regulator = 1'b1;
    step();
    check("hold_heater_on", o_Heater, 1'b1);
    i_Regulator = 1'b0;
    step();
    check("hold_heater_off", o_Heater, 1'b0);

    i_Live = 8'd170;
    wait_state(3'd2, 8, n);
    check("hold_exit_time_ok", (n >= 1 && n <= 4), 1);
    check("hold_exit_state", o_State, 3'd2);
    check("hold_exit_ready", o_Ready, 1'b0);

    i_Live = 8'd180;
    wait_state(3'd3, 40, n);
    check("rehold_state", o_State, 3'd3);

    // Over-temperature from HOLD, clear rules, and target load ignored in FAULT.
    i_Live = 8'd251;
    step();
    check_outputs("overtemp", 3'd4, 8'd0, 1'b0, 1'b0, 1'b1);
    i_Fault_Clear = 1'b1;
    step();
    i_Fault_Clear = 1'b0;
    check("clear_hot_state", o_State, 3'd4);
    check("clear_hot_fault", o_Fault, 1'b1);
    i_Target = 8'd100; i_Target_Load = 1'b1;
    step();
    i_Target_Load = 1'b0;
    check("fault_load_state", o_State, 3'd4);
    i_Live = 8'd200; i_Fault_Clear = 1'b1;
    step();
    i_Fault_Clear = 1'b0;
    check("clear_ok_state", o_State, 3'd0);
    check("clear_ok_fault", o_Fault, 1'b0);
    step();
    check("reramp_state", o_State, 3'd1);
    check("reramp_thresh", o_Thresh, 8'd200);
    i_Live = 8'd180;
    wait_state(3'd2, 100, n);
    check("ramp_down_state", o_State, 3'd2);
    check("ramp_down_thresh", o_Thresh, 8'd180);
    wait_state(3'd3, 40, n);
    check("hold2_state", o_State, 3'd3);

    // Target above MAX_TEMP clamps to 250 and restarts the ramp from 180.
    i_Target = 8'd255; i_Target_Load = 1'b1;
    step();
    i_Target_Load = 1'b0;
    check("clamp_load_state", o_State, 3'd1);
    check("clamp_load_ready", o_Ready, 1'b0);
    check("clamp_load_thresh", o_Thresh, 8'd180);
    wait_state(3'd2, 200, n);
    check("clamp_done_state", o_State, 3'd2);
    check("clamp_done_thresh", o_Thresh, 8'd250);

    // Runaway: heater on, live frozen at 120 below threshold while ramping down to 200.
    i_Live = 8'd120; i_Regulator = 1'b1; i_Target = 8'd200; i_Target_Load = 1'b1;
    step();
    i_Target_Load = 1'b0;
    check("runaway_load_state", o_State, 3'd1);
    wait_state(3'd4, 30, n);
    check("runaway_time_ok", (n >= 10 && n <= 13), 1);
    check_outputs("runaway", 3'd4, 8'd0, 1'b0, 1'b0, 1'b1);

    // Enable dropped mid-ramp.
    i_Fault_Clear = 1'b1;
    step();
    i_Fault_Clear = 1'b0;
    check("clear2_state", o_State, 3'd0);
    step();
    step();
    check("ramp3_state", o_State, 3'd1);
    check("ramp3_heater", o_Heater, 1'b1);
    i_Enable = 1'b0;
    step();
    check_outputs("disable", 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);

    // Reset taken while in SETTLE drops everything, including the loaded target.
    i_Regulator = 1'b0; i_Live = 8'd200; i_Enable = 1'b1;
    wait_state(3'd2, 6, n);
    check("pre_reset_state", o_State, 3'd2);
    i_Reset = 1'b1;
    step();
    check_outputs("mid_reset", 3'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    i_Reset = 1'b0; i_Live = 8'd100;
    wait_state(3'd2, 250, n);
    check("post_reset_state", o_State, 3'd2);
    check("post_reset_target", o_Thresh, 8'd180);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
